// File: rtl/fuzzy_pwm_pkg.sv
// fuzzy_pwm_pkg: shared PWM geometry and slew state encoding
package fuzzy_pwm_pkg;
  localparam int PW_W = 12;
  localparam int CLK_PER_TICK = 3;
  typedef enum logic [1:0] {IDLE, UP, DN} slew_state_t;
endpackage

// File: rtl/period_timer.sv
// period_timer: free-running PWM period counter with an end-of-period strobe
module period_timer #(
  parameter int PER = 12288
) (
  input  logic clk,
  input  logic rst_n,
  output logic period_start
);
  localparam int W = $clog2(PER);
  localparam logic [W-1:0] LAST = W'(PER - 1);
  logic [W-1:0] pcnt;
  always_ff @(posedge clk)
    if (!rst_n) pcnt <= '0;
    else pcnt <= (pcnt == LAST) ? '0 : pcnt + 1'b1;
  assign period_start = rst_n && (pcnt == LAST);
endmodule

// File: rtl/duty_slew_limiter.sv
// duty_slew_limiter: limits PW change to MAX_STEP per PWM period toward the latest target
module duty_slew_limiter #(
  parameter int PW_W = fuzzy_pwm_pkg::PW_W,
  parameter int CLK_PER_TICK = fuzzy_pwm_pkg::CLK_PER_TICK,
  parameter int MAX_STEP = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [PW_W-1:0] tgt_duty,
  input  logic            tgt_valid,
  output logic            tgt_ready,
  output logic [PW_W-1:0] PW,
  output logic            period_start,
  output logic            busy
);
  import fuzzy_pwm_pkg::*;
  localparam int PER = (1 << PW_W) * CLK_PER_TICK;
  localparam logic [PW_W:0] STEP = (PW_W + 1)'(MAX_STEP);
  logic [PW_W-1:0] tgt_q, pw_nxt, tgt_nxt;
  logic [PW_W:0] up_sum, dn_dif;
  slew_state_t state;
  period_timer #(.PER(PER)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .period_start(period_start)
  );
  // one extra bit keeps the step from wrapping at either endpoint
  always_comb begin
    up_sum = {1'b0, PW} + STEP;
    dn_dif = {1'b0, PW} - STEP;
    tgt_nxt = tgt_valid ? tgt_duty : tgt_q;
    pw_nxt = !enable ? '0 :
             !period_start ? PW :
             state == UP ? ((up_sum > {1'b0, tgt_q}) ? tgt_q : up_sum[PW_W-1:0]) :
             state == DN ? ((dn_dif[PW_W] || dn_dif[PW_W-1:0] < tgt_q) ? tgt_q : dn_dif[PW_W-1:0]) :
             PW;
  end
  // state is decoded from the next PW/target so it always matches the registered pair
  always_ff @(posedge clk)
    if (!rst_n) begin
      PW <= '0;
      tgt_q <= '0;
      state <= IDLE;
    end else begin
      PW <= pw_nxt;
      tgt_q <= tgt_nxt;
      state <= (pw_nxt < tgt_nxt) ? UP : (pw_nxt > tgt_nxt) ? DN : IDLE;
    end
  assign tgt_ready = rst_n;
  assign busy = rst_n && enable && (state != IDLE);
endmodule

// File: tb/tb_duty_slew_limiter.sv
// tb_duty_slew_limiter: directed checks on a scaled instance (8-bit duty, 1 clk/tick, step 16)
module tb_duty_slew_limiter;
  localparam int PER = 256;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic tgt_valid = 1'b0;
  logic [7:0] tgt_duty = '0;
  logic tgt_ready, period_start, busy;
  logic [7:0] pw;
  int n_cmp = 0;
  int n_bad = 0;

  duty_slew_limiter #(.PW_W(8), .CLK_PER_TICK(1), .MAX_STEP(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .tgt_duty(tgt_duty),
    .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready),
    .PW(pw),
    .period_start(period_start),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ps();
    for (int i = 0; i < 2 * PER && !period_start; i++) tick();
    if (!period_start) chk("period_start_timeout", 0, 1);
  endtask

  task automatic next_boundary();
    wait_ps();
    tick();
  endtask

  task automatic accept(input int v);
    tgt_valid = 1'b1;
    tgt_duty = 8'(v);
    tick();
    tgt_valid = 1'b0;
  endtask

  task automatic release_and_count(input string tag);
    int cnt;
    cnt = 0;
    rst_n = 1'b1;
    while (!period_start && cnt < 2 * PER) begin
      tick();
      cnt++;
    end
    chk(tag, cnt, PER - 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int e;
    tick();
    tick();
    chk("rst_pw", pw, 0);
    chk("rst_ps", period_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tgt_ready, 0);
    release_and_count("first_ps_after_release");
    chk("ready_run", tgt_ready, 1);
    tick();
    accept(40);
    chk("busy_up", busy, 1);
    next_boundary(); chk("ramp_b1", pw, 16);
    next_boundary(); chk("ramp_b2", pw, 32);
    chk("busy_mid", busy, 1);
    next_boundary(); chk("ramp_b3", pw, 40);
    chk("busy_done", busy, 0);
    accept(255);
    for (int k = 1; k <= 14; k++) begin
      next_boundary();
      e = 40 + 16 * k;
      chk($sformatf("top_b%0d", k), pw, e > 255 ? 255 : e);
    end
    chk("top_busy", busy, 0);
    next_boundary(); chk("top_hold", pw, 255);
    accept(0);
    for (int k = 1; k <= 16; k++) begin
      next_boundary();
      e = 255 - 16 * k;
      chk($sformatf("dn_b%0d", k), pw, e < 0 ? 0 : e);
    end
    chk("dn_busy", busy, 0);
    next_boundary(); chk("dn_hold", pw, 0);
    accept(200);
    next_boundary(); next_boundary(); next_boundary();
    chk("up48", pw, 48);
    wait_ps();
    tgt_valid = 1'b1;
    tgt_duty = 8'd0;
    tick();
    tgt_valid = 1'b0;
    chk("race_old_tgt", pw, 64);
    next_boundary(); chk("race_new_tgt", pw, 48);
    accept(200);
    next_boundary(); chk("pre_dis", pw, 64);
    repeat (3) tick();
    enable = 1'b0;
    tick();
    chk("dis_pw", pw, 0);
    chk("dis_busy", busy, 0);
    repeat (4) tick();
    chk("dis_hold", pw, 0);
    enable = 1'b1;
    tick();
    chk("reen_busy", busy, 1);
    next_boundary(); chk("reen_b1", pw, 16);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_pw", pw, 0);
    chk("mid_rst_ps", period_start, 0);
    chk("mid_rst_ready", tgt_ready, 0);
    chk("mid_rst_busy", busy, 0);
    release_and_count("ps_after_mid_rst");
    tick();
    chk("post_rst_pw", pw, 0);
    chk("post_rst_busy", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
